// File: rtl/int_sync_gateway_arbiter.sv
// Interrupt gateway with per-source IDLE/PENDING/INSERVICE tracking and a locked round-robin claim arbiter.
// Optional macro INT_GW_SYNC_EN adds a 2-flop input synchroniser per source.
module int_sync_gateway_arbiter #(
   parameter int N_SRC = 4
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic [N_SRC-1:0]                      auto_in,
   input  logic [N_SRC-1:0]                      int_enable,
   output logic                                  auto_out_sync_0,
   output logic                                  claim_valid,
   input  logic                                  claim_ready,
   output logic [((N_SRC>1)?$clog2(N_SRC):1)-1:0] claim_id,
   input  logic                                  complete_valid,
   input  logic [((N_SRC>1)?$clog2(N_SRC):1)-1:0] complete_id,
   output logic [N_SRC-1:0]                      pending,
   output logic [N_SRC-1:0]                      in_service
);

   localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_PENDING   = 2'd1,
      S_INSERVICE = 2'd2
   } src_state_t;

   src_state_t        state_q [N_SRC];
   src_state_t        state_d [N_SRC];
   logic [N_SRC-1:0]  in_q;
   logic [N_SRC-1:0]  elig;
   logic [ID_W-1:0]   rr_ptr;
   logic              lock_valid;
   logic [ID_W-1:0]   lock_id;
   logic              lock_hit;
   logic              hi_found;
   logic              lo_found;
   logic [ID_W-1:0]   hi_sel;
   logic [ID_W-1:0]   lo_sel;
   logic [ID_W-1:0]   sel;
   logic              handshake;

`ifdef INT_GW_SYNC_EN
   logic [N_SRC-1:0] sync_a;
   logic [N_SRC-1:0] sync_b;

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= auto_in;
         sync_b <= sync_a;
      end
   end

   assign in_q = sync_b;
`else
   assign in_q = auto_in;
`endif

   always_comb begin
      pending    = '0;
      in_service = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         pending[i]    = (state_q[i] == S_PENDING);
         in_service[i] = (state_q[i] == S_INSERVICE);
      end
   end

   assign elig = pending & int_enable;

   // Round-robin as two passes: first eligible index at/above rr_ptr, else lowest eligible (wrap).
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_sel   = '0;
      lo_sel   = '0;
      lock_hit = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (!hi_found && elig[i] && (ID_W'(i) >= rr_ptr)) begin
            hi_found = 1'b1;
            hi_sel   = ID_W'(i);
         end
         if (!lo_found && elig[i]) begin
            lo_found = 1'b1;
            lo_sel   = ID_W'(i);
         end
         if (lock_valid && (ID_W'(i) == lock_id) && elig[i]) begin
            lock_hit = 1'b1;
         end
      end
      if (lock_hit) begin
         sel = lock_id;
      end else if (hi_found) begin
         sel = hi_sel;
      end else begin
         sel = lo_sel;
      end
   end

   assign claim_valid     = |elig;
   assign auto_out_sync_0 = |elig;
   assign claim_id        = claim_valid ? sel : '0;
   assign handshake       = claim_valid & claim_ready;

   // Completes only match indices below N_SRC, so out-of-range ids fall through untouched.
   always_comb begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            S_IDLE: begin
               if (in_q[i] && int_enable[i]) begin
                  state_d[i] = S_PENDING;
               end
            end
            S_PENDING: begin
               if (handshake && (sel == ID_W'(i))) begin
                  state_d[i] = S_INSERVICE;
               end
            end
            S_INSERVICE: begin
               if (complete_valid && (complete_id == ID_W'(i))) begin
                  state_d[i] = S_IDLE;
               end
            end
            default: state_d[i] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int unsigned i = 0; i < N_SRC; i++) begin
            state_q[i] <= S_IDLE;
         end
         rr_ptr     <= '0;
         lock_valid <= 1'b0;
         lock_id    <= '0;
      end else begin
         for (int unsigned i = 0; i < N_SRC; i++) begin
            state_q[i] <= state_d[i];
         end
         if (handshake) begin
            rr_ptr     <= (sel == ID_W'(N_SRC - 1)) ? '0 : sel + 1'b1;
            lock_valid <= 1'b0;
         end else begin
            // Re-registering the current pick each cycle also re-locks after a masked release.
            lock_valid <= claim_valid;
            lock_id    <= sel;
         end
      end
   end

endmodule
